// File: rtl/rapid_pkg.sv
// Shared RV32I definitions: data width and the decoded control bundle.
package rapid_pkg;

    localparam int XLEN = 32;

    // Decoded control for one instruction; all-zero is the "no-op" bundle.
    typedef struct packed {
        logic       load_upper_imm;
        logic       uncond_branch;
        logic       cond_branch;
        logic       mem;
        logic       alu_imm;
        logic       alu_reg;
        logic       iop;
        logic [2:0] fcs_opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_out;
        logic       rs2_out;
    } control_s;

    function automatic control_s control_s_default();
        return '0;
    endfunction

endpackage

// File: rtl/decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry queue of decoded instructions.
// Decode happens combinationally on the fetch side; the queue stores the
// decoded result so execute sees registered control/immediate at the head.
module decode_queue
    import rapid_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_instruction,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        control_s        ctrl;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;

    control_s         dec_ctrl;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    logic             push, pop;
    entry_t           head;

    logic [31:0] instr;
    assign instr = i_instruction;

    // Combinational RV32I decode of the incoming word.
    always_comb begin
        dec_ctrl = control_s_default();
        dec_imm  = '0;
        dec_ill  = 1'b0;
        case (instr[6:0])
            7'b0110111: begin // LUI
                dec_ctrl.load_upper_imm = 1'b1;
                dec_imm                 = {instr[31:12], 12'b0};
                dec_ctrl.rd             = instr[11:7];
            end
            7'b0010111: begin // AUIPC
                dec_ctrl.load_upper_imm = 1'b1;
                dec_ctrl.iop            = 1'b1;
                dec_imm                 = {instr[31:12], 12'b0};
                dec_ctrl.rd             = instr[11:7];
            end
            7'b1101111: begin // JAL
                dec_ctrl.uncond_branch = 1'b1;
                dec_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_ctrl.rd            = instr[11:7];
            end
            7'b1100111: begin // JALR
                dec_ctrl.uncond_branch = 1'b1;
                dec_ctrl.iop           = 1'b1;
                dec_imm  = {{20{instr[31]}}, instr[31:20]};
                dec_ctrl.rs1     = instr[19:15];
                dec_ctrl.rs1_out = 1'b1;
                dec_ctrl.rd      = instr[11:7];
            end
            7'b1100011: begin // BRANCH
                dec_ctrl.cond_branch = 1'b1;
                dec_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_ctrl.rs1     = instr[19:15];
                dec_ctrl.rs2     = instr[24:20];
                dec_ctrl.rs1_out = 1'b1;
                dec_ctrl.rs2_out = 1'b1;
            end
            7'b0000011: begin // LOAD
                dec_ctrl.mem     = 1'b1;
                dec_imm          = {{20{instr[31]}}, instr[31:20]};
                dec_ctrl.rs1     = instr[19:15];
                dec_ctrl.rs1_out = 1'b1;
                dec_ctrl.rd      = instr[11:7];
            end
            7'b0100011: begin // STORE
                dec_ctrl.mem     = 1'b1;
                dec_ctrl.iop     = 1'b1;
                dec_imm          = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_ctrl.rs1     = instr[19:15];
                dec_ctrl.rs2     = instr[24:20];
                dec_ctrl.rs1_out = 1'b1;
                dec_ctrl.rs2_out = 1'b1;
            end
            7'b0010011: begin // OP-IMM: only the shift-right pair uses bit 30
                dec_ctrl.alu_imm = 1'b1;
                dec_ctrl.iop     = (instr[14:12] == 3'b101) ? instr[30] : 1'b0;
                dec_imm          = {{20{instr[31]}}, instr[31:20]};
                dec_ctrl.rs1     = instr[19:15];
                dec_ctrl.rs1_out = 1'b1;
                dec_ctrl.rd      = instr[11:7];
            end
            7'b0110011: begin // OP
                dec_ctrl.alu_reg = 1'b1;
                dec_ctrl.iop     = instr[30];
                dec_ctrl.rs1     = instr[19:15];
                dec_ctrl.rs2     = instr[24:20];
                dec_ctrl.rs1_out = 1'b1;
                dec_ctrl.rs2_out = 1'b1;
                dec_ctrl.rd      = instr[11:7];
            end
            // Any opcode not listed, including all with [1:0]!=2'b11.
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_ctrl = control_s_default();
            dec_imm  = '0;
        end else begin
            dec_ctrl.fcs_opcode = instr[14:12];
        end
    end

    assign o_ready = (count < CNT_W'(DEPTH));
    assign o_valid = (count != '0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign o_count = count;

    // Head entry, forced to neutral values when the queue is empty.
    always_comb begin
        head             = mem_q[rd_ptr];
        o_pc             = o_valid ? head.pc      : '0;
        o_control_signal = o_valid ? head.ctrl    : control_s_default();
        o_imm            = o_valid ? head.imm     : '0;
        o_illegal        = o_valid ? head.illegal : 1'b0;
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (push && !i_flush)
            mem_q[wr_ptr] <= '{pc: i_pc, ctrl: dec_ctrl, imm: dec_imm, illegal: dec_ill};
    end

    // Pointer/occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (i_flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_decode_queue;
    import rapid_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_reset, i_valid, i_flush, i_ready;
    logic [31:0]      i_instruction, i_pc;
    logic             o_ready, o_valid, o_illegal;
    logic [31:0]      o_pc, o_imm;
    control_s         o_control_signal;
    logic [CNT_W-1:0] o_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        control_s    ctrl;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t mq[$];

    decode_queue #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
        .o_control_signal(o_control_signal), .o_imm(o_imm),
        .o_illegal(o_illegal), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    // Reference decode: pick the instruction class from the opcode, then
    // fill register fields from which operands that class uses.
    function automatic exp_t m_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        bit   use_rd, use_rs1, use_rs2;
        e.pc = pc; e.ctrl = '0; e.imm = '0; e.ill = 1'b0;
        use_rd = 0; use_rs1 = 0; use_rs2 = 0;
        case (w[6:0])
            7'h37: begin e.ctrl.load_upper_imm = 1; e.imm = w & 32'hFFFF_F000; use_rd = 1; end
            7'h17: begin e.ctrl.load_upper_imm = 1; e.ctrl.iop = 1; e.imm = w & 32'hFFFF_F000; use_rd = 1; end
            7'h6F: begin e.ctrl.uncond_branch = 1; use_rd = 1;
                         e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h67: begin e.ctrl.uncond_branch = 1; e.ctrl.iop = 1; use_rd = 1; use_rs1 = 1;
                         e.imm = 32'($signed(w[31:20])); end
            7'h63: begin e.ctrl.cond_branch = 1; use_rs1 = 1; use_rs2 = 1;
                         e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h03: begin e.ctrl.mem = 1; use_rd = 1; use_rs1 = 1; e.imm = 32'($signed(w[31:20])); end
            7'h23: begin e.ctrl.mem = 1; e.ctrl.iop = 1; use_rs1 = 1; use_rs2 = 1;
                         e.imm = 32'($signed({w[31:25], w[11:7]})); end
            7'h13: begin e.ctrl.alu_imm = 1; use_rd = 1; use_rs1 = 1; e.imm = 32'($signed(w[31:20]));
                         e.ctrl.iop = (w[14:12] == 3'd5) && w[30]; end
            7'h33: begin e.ctrl.alu_reg = 1; e.ctrl.iop = w[30]; use_rd = 1; use_rs1 = 1; use_rs2 = 1; end
            default: e.ill = 1'b1;
        endcase
        if (!e.ill) begin
            e.ctrl.fcs_opcode = w[14:12];
            if (use_rd)  e.ctrl.rd = w[11:7];
            if (use_rs1) begin e.ctrl.rs1 = w[19:15]; e.ctrl.rs1_out = 1; end
            if (use_rs2) begin e.ctrl.rs2 = w[24:20]; e.ctrl.rs2_out = 1; end
        end
        return e;
    endfunction

    // Apply one clock edge to the model using the inputs that were present.
    task automatic model_edge();
        bit psh, pp;
        psh = i_valid && (mq.size() < DEPTH);
        pp  = (mq.size() != 0) && i_ready;
        if (i_reset || i_flush) mq.delete();
        else begin
            if (pp)  void'(mq.pop_front());
            if (psh) mq.push_back(m_decode(i_instruction, i_pc));
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] pc,
                         input bit rdy, input bit fl);
        i_valid = v; i_instruction = w; i_pc = pc; i_ready = rdy; i_flush = fl;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 0);
        tick(); tick();
        checks++; if (o_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_count !== '0)    begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
        checks++; if (o_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        checks++; if (o_pc !== 32'h0 || o_imm !== 32'h0 || o_illegal !== 1'b0 || o_control_signal !== control_s_default())
            begin errors++; $display("FAIL reset_data got pc=%h imm=%h ill=%b ctrl=%h want zeros", o_pc, o_imm, o_illegal, o_control_signal); end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        drive(1, 32'h0050_0093, 32'h100, 1, 0);
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        checks++; if (o_valid !== 1'b1 || o_count !== 2'd1) begin errors++; $display("FAIL addi_valid got v=%b c=%0d want v=1 c=1", o_valid, o_count); end
        checks++; if (o_control_signal.alu_imm !== 1'b1 || o_control_signal.rd !== 5'd1 || o_control_signal.rs1_out !== 1'b1)
            begin errors++; $display("FAIL addi_ctrl got %h", o_control_signal); end
        checks++; if (o_imm !== 32'd5 || o_pc !== 32'h100) begin errors++; $display("FAIL addi_imm got imm=%h pc=%h want 5/100", o_imm, o_pc); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b want 0", o_valid); end
    endtask

    task automatic test_decode_fields();
        drive(1, 32'h4030_D113, 32'h10, 1, 0);   // SRAI x2,x1,3
        tick();
        drive(1, 32'h4000_8093, 32'h14, 1, 0);   // ADDI x1,x1,0x400 (bit30 set)
        checks++; if (o_control_signal.iop !== 1'b1 || o_control_signal.fcs_opcode !== 3'b101 || o_imm !== 32'h403)
            begin errors++; $display("FAIL srai got iop=%b f3=%b imm=%h want 1/101/403", o_control_signal.iop, o_control_signal.fcs_opcode, o_imm); end
        tick();
        drive(1, 32'hFE00_0CE3, 32'h18, 1, 0);   // BEQ x0,x0,-8
        checks++; if (o_control_signal.iop !== 1'b0 || o_imm !== 32'h400 || o_pc !== 32'h14)
            begin errors++; $display("FAIL addi30 got iop=%b imm=%h pc=%h want 0/400/14", o_control_signal.iop, o_imm, o_pc); end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        checks++; if (o_control_signal.cond_branch !== 1'b1 || o_control_signal.rs1_out !== 1'b1 ||
                      o_control_signal.rs2_out !== 1'b1 || o_imm !== 32'hFFFF_FFF8)
            begin errors++; $display("FAIL beq got ctrl=%h imm=%h want imm fffffff8", o_control_signal, o_imm); end
        tick();
    endtask

    task automatic test_backpressure();
        drive(1, 32'h0010_0093, 32'h200, 0, 0); tick();
        drive(1, 32'h0020_0093, 32'h204, 0, 0); tick();
        checks++; if (o_ready !== 1'b0 || o_count !== 2'd2) begin errors++; $display("FAIL bp_full got r=%b c=%0d want 0/2", o_ready, o_count); end
        drive(1, 32'h0030_0093, 32'h208, 0, 0); tick();
        checks++; if (o_count !== 2'd2 || o_pc !== 32'h200) begin errors++; $display("FAIL bp_hold got c=%0d pc=%h want 2/200", o_count, o_pc); end
        drive(1, 32'h0030_0093, 32'h208, 1, 0); tick();
        checks++; if (o_count !== 2'd1 || o_pc !== 32'h204 || o_imm !== 32'd2 || o_ready !== 1'b1)
            begin errors++; $display("FAIL bp_pop1 got c=%0d pc=%h imm=%h r=%b want 1/204/2/1", o_count, o_pc, o_imm, o_ready); end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        checks++; if (o_count !== 2'd1 || o_pc !== 32'h208 || o_imm !== 32'd3)
            begin errors++; $display("FAIL bp_order got c=%0d pc=%h imm=%h want 1/208/3", o_count, o_pc, o_imm); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 32'h0010_0093, 32'h300, 0, 0); tick(); tick();
        drive(1, 32'h0050_0093, 32'h308, 0, 1); tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        checks++; if (o_count !== '0 || o_valid !== 1'b0 || o_ready !== 1'b1)
            begin errors++; $display("FAIL flush got c=%0d v=%b r=%b want 0/0/1", o_count, o_valid, o_ready); end
        tick();
        checks++; if (o_count !== '0) begin errors++; $display("FAIL flush_drop got c=%0d want 0", o_count); end
    endtask

    task automatic test_illegal();
        drive(1, 32'hFFFF_FFFF, 32'h400, 1, 0); tick();
        drive(1, 32'h0050_0090, 32'h404, 1, 0);
        checks++; if (o_illegal !== 1'b1 || o_imm !== 32'h0 || o_control_signal !== control_s_default())
            begin errors++; $display("FAIL ill_ones got ill=%b imm=%h ctrl=%h want 1/0/0", o_illegal, o_imm, o_control_signal); end
        tick();
        drive(1, 32'h1234_5037, 32'h408, 1, 0);
        checks++; if (o_illegal !== 1'b1 || o_pc !== 32'h404) begin errors++; $display("FAIL ill_low got ill=%b pc=%h want 1/404", o_illegal, o_pc); end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        checks++; if (o_illegal !== 1'b0 || o_imm !== 32'h1234_5000 || o_control_signal.load_upper_imm !== 1'b1)
            begin errors++; $display("FAIL lui got ill=%b imm=%h want 0/12345000", o_illegal, o_imm); end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 32'h0010_0093, 32'h500, 0, 0); tick(); tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        #2 i_reset = 1'b1;
        #1;
        mq.delete();
        checks++; if (o_valid !== 1'b0 || o_count !== '0) begin errors++; $display("FAIL async_rst got v=%b c=%0d want 0/0", o_valid, o_count); end
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] r, w;
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            w = ($urandom_range(0, 4) == 0) ? r : {r[31:7], ops[$urandom_range(0, 8)]};
            drive($urandom_range(0, 3) != 0, w, $urandom(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (o_count !== CNT_W'(mq.size()) || o_valid !== (mq.size() != 0) || o_ready !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_state[%0d] got c=%0d v=%b r=%b want c=%0d", n, o_count, o_valid, o_ready, mq.size());
            end
            checks++;
            if (mq.size() != 0) begin
                if (o_pc !== mq[0].pc || o_control_signal !== mq[0].ctrl || o_imm !== mq[0].imm || o_illegal !== mq[0].ill) begin
                    errors++; $display("FAIL rand_head[%0d] got pc=%h ctrl=%h imm=%h ill=%b want pc=%h ctrl=%h imm=%h ill=%b",
                        n, o_pc, o_control_signal, o_imm, o_illegal, mq[0].pc, mq[0].ctrl, mq[0].imm, mq[0].ill);
                end
            end else if (o_pc !== 32'h0 || o_imm !== 32'h0 || o_illegal !== 1'b0 || o_control_signal !== control_s_default()) begin
                errors++; $display("FAIL rand_empty[%0d] got pc=%h imm=%h ill=%b", n, o_pc, o_imm, o_illegal);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_decode_fields();
        test_backpressure();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
